// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain sda/scl are only ever pulled low or released; no clock stretching.
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    inout  wire        sda,
    inout  wire        scl
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_WRITE,
        S_ACK2,
        S_READ,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [QW-1:0] q_cnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic [7:0]    wdata_q;
    logic          rw_q;
    logic          accept;
    logic          qtick;
    logic          slot_end;
    logic          sample_pt;
    logic          sda_in;
    logic          sda_low;
    logic          scl_low;

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign accept    = (state == S_IDLE) && start;
    assign qtick     = busy && (q_cnt == Q_LAST);
    assign slot_end  = qtick && (phase == 2'd3);
    // Entering q2 is the SCL rising edge; SDA has been stable since q0.
    assign sample_pt = qtick && (phase == 2'd1);
    assign sda_in    = sda;

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cnt <= '0;
        end else if (!busy || qtick) begin
            q_cnt <= '0;
        end else begin
            q_cnt <= q_cnt + QW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            wdata_q <= 8'h00;
            rw_q    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state <= state_nx;
            if (accept) begin
                tx_sr   <= {addr, rw};
                wdata_q <= wdata;
                rw_q    <= rw;
                ack_err <= 1'b0;
                phase   <= 2'd0;
                bit_cnt <= 3'd0;
            end
            if (qtick) begin
                phase <= phase + 2'd1;
            end
            if (slot_end && (state == S_ADDR || state == S_WRITE || state == S_READ)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (slot_end && (state == S_ADDR || state == S_WRITE)) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (slot_end && state == S_ACK1) begin
                tx_sr <= wdata_q;
            end
            if (sample_pt && (state == S_ACK1 || state == S_ACK2) && sda_in) begin
                ack_err <= 1'b1;
            end
            if (sample_pt && state == S_READ) begin
                rx_sr <= {rx_sr[6:0], sda_in};
            end
            // rdata is only refreshed by a read that got past the address phase.
            if (slot_end && state == S_STOP && rw_q && !ack_err) begin
                rdata <= rx_sr;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_START;
            S_START: if (slot_end) state_nx = S_ADDR;
            S_ADDR:  if (slot_end && bit_cnt == 3'd7) state_nx = S_ACK1;
            S_ACK1: begin
                if (slot_end) begin
                    if (ack_err)   state_nx = S_STOP;
                    else if (rw_q) state_nx = S_READ;
                    else           state_nx = S_WRITE;
                end
            end
            S_WRITE: if (slot_end && bit_cnt == 3'd7) state_nx = S_ACK2;
            S_ACK2:  if (slot_end) state_nx = S_STOP;
            S_READ:  if (slot_end && bit_cnt == 3'd7) state_nx = S_MNACK;
            S_MNACK: if (slot_end) state_nx = S_STOP;
            S_STOP:  if (slot_end) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sda_low = 1'b0;
        scl_low = 1'b0;
        case (state)
            S_START: begin
                sda_low = (phase >= 2'd2);
                scl_low = (phase == 2'd3);
            end
            S_ADDR, S_WRITE: begin
                sda_low = ~tx_sr[7];
                scl_low = (phase < 2'd2);
            end
            S_ACK1, S_ACK2, S_READ, S_MNACK: begin
                scl_low = (phase < 2'd2);
            end
            // SDA rises in q2 while SCL is already released: the STOP condition.
            S_STOP: begin
                sda_low = (phase < 2'd2);
                scl_low = (phase == 2'd0);
            end
            default: begin
                sda_low = 1'b0;
                scl_low = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural responder at 7'h01, latency/result model,
// bus protocol monitor and directed command sequence.
module tb_i2c_master;

    localparam int D = 4;
    localparam logic [6:0] SLV_ADDR = 7'h01;
    localparam logic [7:0] RD_BYTE  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    wire        sda_w;
    wire        scl_w;

    pullup (sda_w);
    pullup (scl_w);

    logic slv_sda_low = 1'b0;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .sda(sda_w), .scl(scl_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responder: ACKs SLV_ADDR, stores a written byte, returns RD_BYTE on reads.
    logic       s_pscl = 1'b1;
    logic       s_psda = 1'b1;
    logic       s_active = 1'b0;
    int         s_cnt = 0;
    logic [7:0] s_abyte = 8'h00;
    logic [7:0] s_dbyte = 8'h00;
    logic       s_match = 1'b0;
    logic       s_rd = 1'b0;
    logic       s_mnack = 1'b0;
    logic [7:0] slave_data_in = 8'h00;
    logic [7:0] rd_byte = RD_BYTE;

    always @(negedge clk) begin
        if (rst) begin
            s_active    = 1'b0;
            slv_sda_low = 1'b0;
        end else if (s_pscl && scl_w && s_psda && !sda_w) begin
            s_active = 1'b1;
            s_cnt    = 0;
            s_match  = 1'b0;
            s_mnack  = 1'b0;
        end else if (s_pscl && scl_w && !s_psda && sda_w) begin
            s_active    = 1'b0;
            slv_sda_low = 1'b0;
        end else if (s_active && !s_pscl && scl_w) begin
            s_cnt++;
            if (s_cnt <= 8) s_abyte = {s_abyte[6:0], sda_w};
            else if (s_cnt >= 10 && s_cnt <= 17) s_dbyte = {s_dbyte[6:0], sda_w};
            if (s_cnt == 8) begin
                s_match = (s_abyte[7:1] == SLV_ADDR);
                s_rd    = s_abyte[0];
            end
            if (s_cnt == 17 && s_match && !s_rd) slave_data_in = s_dbyte;
            if (s_cnt == 18) s_mnack = sda_w;
        end else if (s_active && s_pscl && !scl_w) begin
            slv_sda_low = 1'b0;
            if (s_match) begin
                if (s_cnt == 8) slv_sda_low = 1'b1;
                else if (s_rd && s_cnt >= 9 && s_cnt <= 16) slv_sda_low = !rd_byte[16 - s_cnt];
                else if (!s_rd && s_cnt == 17) slv_sda_low = 1'b1;
            end
        end
        s_pscl = scl_w;
        s_psda = sda_w;
    end

    // Model: a command lasts 80 quarter-periods, 44 when the address is not ACKed.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_ack_err = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_nack = 1'b0;
    logic       m_rw = 1'b0;
    int         m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00; m_cnt = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy    = 1'b0;
                m_done    = 1'b1;
                m_ack_err = m_nack;
                if (m_rw && !m_nack) m_rdata = RD_BYTE;
            end
        end else if (start) begin
            m_busy    = 1'b1;
            m_nack    = (addr != SLV_ADDR);
            m_rw      = rw;
            m_cnt     = (m_nack ? 44 : 80) * D;
            m_ack_err = 1'b0;
        end
    end

    // Bus monitor: SDA edges while SCL stays high are START (fall) or STOP (rise).
    int   pc_starts = 0;
    int   pc_stops = 0;
    logic pc_psda = 1'b1;
    logic pc_pscl = 1'b1;

    always @(negedge clk) begin
        if (rst || (!m_busy && !m_done)) begin
            pc_starts = 0;
            pc_stops  = 0;
        end else if (pc_pscl && scl_w && (pc_psda != sda_w)) begin
            if (!sda_w) pc_starts++;
            else        pc_stops++;
        end
        pc_psda = sda_w;
        pc_pscl = scl_w;
    end

    task automatic compare_cycle();
        if (!rst) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("rdata", rdata, m_rdata);
            if (!m_busy) chk("ack_err", ack_err, m_ack_err);
            if (m_done) begin
                chk("start_cond_count", pc_starts, 1);
                chk("stop_cond_count", pc_stops, 1);
            end
        end
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d cycles expected=done", lat);
        end
    endtask

    task automatic do_cmd(input logic [6:0] a, input logic r, input logic [7:0] wd, output int lat);
        @(negedge clk);
        start = 1'b1; addr = a; rw = r; wdata = wd;
        @(negedge clk);
        start = 1'b0;
        addr  = 7'($urandom_range(0, 127));
        rw    = 1'($urandom_range(0, 1));
        wdata = 8'($urandom_range(0, 255));
        wait_done(0, lat);
    endtask

    initial begin
        int lat;
        int extra;
        rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; wdata = 8'h00;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_sda", sda_w, 1);
        chk("rst_scl", scl_w, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_cmd(7'h01, 1'b0, 8'hA5, lat);
        chk("wr_latency", lat, 320);
        chk("wr_ack_err", ack_err, 0);
        chk("wr_slave_data", slave_data_in, 8'hA5);
        chk("wr_rdata_hold", rdata, 8'h00);

        do_cmd(7'h01, 1'b1, 8'h00, lat);
        chk("rd_latency", lat, 320);
        chk("rd_rdata", rdata, 8'h5A);
        chk("rd_ack_err", ack_err, 0);
        chk("rd_master_nack", s_mnack, 1);

        do_cmd(7'h22, 1'b1, 8'h00, lat);
        chk("nack_latency", lat, 176);
        chk("nack_ack_err", ack_err, 1);
        chk("nack_rdata_hold", rdata, 8'h5A);

        @(negedge clk);
        start = 1'b1; addr = 7'h01; rw = 1'b0; wdata = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1; addr = 7'h22; rw = 1'b1; wdata = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(51, lat);
        chk("busy_start_latency", lat, 320);
        chk("busy_start_ack_err", ack_err, 0);
        chk("busy_start_slave_data", slave_data_in, 8'h3C);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("busy_start_extra_done", extra, 0);

        @(negedge clk);
        start = 1'b1; addr = 7'h01; rw = 1'b0; wdata = 8'h77;
        @(negedge clk);
        start = 1'b0;
        repeat (65) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sda", sda_w, 1);
        chk("midrst_scl", scl_w, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata", rdata, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_cmd(7'h01, 1'b0, 8'hC3, lat);
        chk("post_rst_latency", lat, 320);
        chk("post_rst_ack_err", ack_err, 0);
        chk("post_rst_slave_data", slave_data_in, 8'hC3);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
